// File: rtl/decode_stage.sv
// decode_stage: RV32I ID stage with an ID/EX pipeline register.
// Drives regfile read addresses and read enables. Inserts one bubble per
// load-use pair. Flush has priority over stall and over EX back-pressure.
// Optional macro DECODE_ILLEGAL_CHECK_EN adds the illegal-opcode flag.
module decode_stage #(
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_insn,
    input  logic        flush,
    output logic        rs1pass,
    output logic [4:0]  rs1addr,
    output logic        rs2pass,
    output logic [4:0]  rs2addr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_insn,
    output logic [31:0] out_imm,
    output logic [31:0] out_rs1val,
    output logic [31:0] out_rs2val,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]  opc;
    logic [4:0]  rd;
    logic        is_load, is_misc, is_opimm, is_auipc, is_store, is_op;
    logic        is_lui, is_branch, is_jalr, is_jal, is_system;
    logic        dec_wen;
    logic [31:0] dec_imm;
    logic        advance, hazard, take, bubble;

    assign opc       = in_insn[6:0];
    assign rd        = in_insn[11:7];
    assign is_load   = (opc == OPC_LOAD);
    assign is_misc   = (opc == OPC_MISC);
    assign is_opimm  = (opc == OPC_OPIMM);
    assign is_auipc  = (opc == OPC_AUIPC);
    assign is_store  = (opc == OPC_STORE);
    assign is_op     = (opc == OPC_OP);
    assign is_lui    = (opc == OPC_LUI);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_jalr   = (opc == OPC_JALR);
    assign is_jal    = (opc == OPC_JAL);
    assign is_system = (opc == OPC_SYSTEM);

    // Regfile addresses come straight from the word, valid or not.
    assign rs1addr = in_insn[19:15];
    assign rs2addr = in_insn[24:20];
    assign rs1pass = in_valid & (is_op | is_opimm | is_load | is_store | is_branch | is_jalr);
    assign rs2pass = in_valid & (is_op | is_store | is_branch);

    // Only recognised writers qualify, so an illegal word can never write rd.
    assign dec_wen = (is_op | is_opimm | is_load | is_lui | is_auipc | is_jal | is_jalr)
                   & (rd != 5'd0);

    // Immediate by instruction format; R-type and unknown opcodes give 0.
    always_comb begin
        dec_imm = '0;
        if (is_opimm | is_load | is_jalr | is_misc | is_system)
            dec_imm = {{20{in_insn[31]}}, in_insn[31:20]};
        else if (is_store)
            dec_imm = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
        else if (is_branch)
            dec_imm = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25],
                       in_insn[11:8], 1'b0};
        else if (is_lui | is_auipc)
            dec_imm = {in_insn[31:12], 12'b0};
        else if (is_jal)
            dec_imm = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20],
                       in_insn[30:21], 1'b0};
    end

    // A load in ID/EX whose rd is read by the incoming word stalls one cycle.
    // Pass bits already include in_valid, and rd != 0 rules out x0 operands.
    assign hazard  = out_valid & (out_insn[6:0] == OPC_LOAD) & (out_rd != 5'd0)
                   & ((rs1pass & (rs1addr == out_rd)) | (rs2pass & (rs2addr == out_rd)));
    assign advance = out_ready | ~out_valid;
    assign in_ready = (advance & ~hazard) | flush;
    assign take    = ~flush & advance & in_valid & ~hazard;
    assign bubble  = flush | (advance & ~take);

    // ID/EX register: capture, insert a bubble, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_insn   <= NOP_INSN;
            out_imm    <= '0;
            out_rs1val <= '0;
            out_rs2val <= '0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
        end else if (take) begin
            out_valid  <= 1'b1;
            out_pc     <= in_pc;
            out_insn   <= in_insn;
            out_imm    <= dec_imm;
            out_rs1val <= rs1;
            out_rs2val <= rs2;
            out_rd     <= rd;
            out_wen    <= dec_wen;
        end else if (bubble) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_insn   <= NOP_INSN;
            out_imm    <= '0;
            out_rs1val <= '0;
            out_rs2val <= '0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    // Every base opcode ends in 2'b11, so a non-match also covers insn[1:0].
    logic dec_illegal;
    assign dec_illegal = ~(is_load | is_misc | is_opimm | is_auipc | is_store | is_op
                         | is_lui | is_branch | is_jalr | is_jal | is_system);

    // Illegal flag travels with the captured instruction; cleared on bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_illegal <= 1'b0;
        else if (take)
            out_illegal <= dec_illegal;
        else if (bubble)
            out_illegal <= 1'b0;
    end
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_decode_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0070_0293;  // addi x5,x0,7
    localparam logic [31:0] LW   = 32'h0000_A303;  // lw x6,0(x1)
    localparam logic [31:0] ADD  = 32'h0023_03B3;  // add x7,x6,x2
    localparam logic [31:0] BEQ  = 32'hFE20_8CE3;  // beq x1,x2,-8

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_ready;
    logic [31:0] in_pc, in_insn, rs1, rs2;
    logic        rs1pass, rs2pass, out_valid, out_wen, out_illegal;
    logic [4:0]  rs1addr, rs2addr, out_rd;
    logic [31:0] out_pc, out_insn, out_imm, out_rs1val, out_rs2val;
    logic [31:0] regfile [32];

    int n_chk = 0;
    int n_fail = 0;

    decode_stage #(.NOP_INSN(NOP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_insn(in_insn), .flush(flush),
        .rs1pass(rs1pass), .rs1addr(rs1addr), .rs2pass(rs2pass), .rs2addr(rs2addr),
        .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn), .out_imm(out_imm),
        .out_rs1val(out_rs1val), .out_rs2val(out_rs2val), .out_rd(out_rd),
        .out_wen(out_wen), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Combinational regfile stand-in.
    assign rs1 = regfile[rs1addr];
    assign rs2 = regfile[rs2addr];

    typedef struct packed {
        logic        v;
        logic [31:0] pc, insn, imm, r1, r2;
        logic [4:0]  rd;
        logic        wen, ill;
    } st_t;

    localparam st_t BUB = '{v: 1'b0, pc: 32'd0, insn: NOP, imm: 32'd0, r1: 32'd0,
                            r2: 32'd0, rd: 5'd0, wen: 1'b0, ill: 1'b0};

    function automatic logic known(logic [6:0] o);
        case (o)
            7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
            7'h63, 7'h67, 7'h6F, 7'h73: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads1(logic [6:0] o);
        return o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic logic reads2(logic [6:0] o);
        return o inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic logic writes(logic [6:0] o);
        return o inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
    endfunction

    function automatic logic [31:0] mimm(logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return {{20{i[31]}}, i[31:20]};
            7'h23: return {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'h37, 7'h17: return {i[31:12], 12'b0};
            7'h6F: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_hazard(st_t cur, logic iv, logic [31:0] insn);
        logic [4:0] d;
        d = cur.rd;
        if (!iv || !cur.v || cur.insn[6:0] != 7'h03 || d == 5'd0) return 1'b0;
        return (reads1(insn[6:0]) && insn[19:15] == d) || (reads2(insn[6:0]) && insn[24:20] == d);
    endfunction

    function automatic st_t m_next(st_t cur, logic iv, logic [31:0] pc, logic [31:0] insn,
                                   logic fl, logic rdy, logic [31:0] v1, logic [31:0] v2);
        st_t n;
        n = cur;
        if (fl) n = BUB;
        else if (rdy || !cur.v) begin
            if (iv && !m_hazard(cur, iv, insn)) begin
                n.v = 1'b1; n.pc = pc; n.insn = insn; n.imm = mimm(insn);
                n.r1 = v1; n.r2 = v2; n.rd = insn[11:7];
                n.wen = writes(insn[6:0]) && insn[11:7] != 5'd0;
`ifdef DECODE_ILLEGAL_CHECK_EN
                n.ill = !known(insn[6:0]);
`else
                n.ill = 1'b0;
`endif
            end else n = BUB;
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    st_t ms;

    // Reference model state tracks the ID/EX register.
    always @(posedge clk or posedge rst) begin
        if (rst) ms <= BUB;
        else ms <= m_next(ms, in_valid, in_pc, in_insn, flush, out_ready,
                          regfile[in_insn[19:15]], regfile[in_insn[24:20]]);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic p1, p2, er;
        p1 = in_valid && reads1(in_insn[6:0]);
        p2 = in_valid && reads2(in_insn[6:0]);
        er = ((out_ready || !ms.v) && !m_hazard(ms, in_valid, in_insn)) || flush;
        chk("rs1addr", 32'(rs1addr), 32'(in_insn[19:15]));
        chk("rs2addr", 32'(rs2addr), 32'(in_insn[24:20]));
        chk("rs1pass", 32'(rs1pass), 32'(p1));
        chk("rs2pass", 32'(rs2pass), 32'(p2));
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(ms.v));
        chk("out_insn", out_insn, ms.insn);
        chk("out_wen", 32'(out_wen), 32'(ms.wen));
        chk("out_illegal", 32'(out_illegal), 32'(ms.ill));
        if (ms.v || rst) begin
            chk("out_pc", out_pc, ms.pc);
            chk("out_imm", out_imm, ms.imm);
            chk("out_rs1val", out_rs1val, ms.r1);
            chk("out_rs2val", out_rs2val, ms.r2);
            chk("out_rd", 32'(out_rd), 32'(ms.rd));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(logic v, logic [31:0] w);
        in_valid = v;
        in_insn = w;
        in_pc = in_pc + 32'd4;
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] w;
        logic [6:0]  o;
        int k;
        w = $urandom;
        k = $urandom_range(0, 13);
        case (k)
            0, 1, 2: o = 7'h03;
            3: o = 7'h13;  4: o = 7'h33;  5: o = 7'h23;  6: o = 7'h63;
            7: o = 7'h67;  8: o = 7'h6F;  9: o = 7'h37;  10: o = 7'h17;
            11: o = 7'h73; 12: o = 7'h0F;
            default: o = w[6:0];
        endcase
        w[6:0]   = o;
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        logic took;
        for (int i = 0; i < 32; i++) regfile[i] = $urandom;
        rst = 1'b1; in_valid = 1'b0; in_insn = 32'd0; in_pc = 32'h100;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_insn", out_insn, NOP);
        chk("rst out_imm", out_imm, 32'd0);
        rst = 1'b0;
        #1 chk("post-rst in_ready", 32'(in_ready), 32'd1);

        // addi x5,x0,7
        put(1'b1, ADDI);
        #1 chk("addi rs1pass", 32'(rs1pass), 32'd1);
        chk("addi rs2pass", 32'(rs2pass), 32'd0);
        step();
        chk("addi valid", 32'(out_valid), 32'd1);
        chk("addi imm", out_imm, 32'd7);
        chk("addi rd", 32'(out_rd), 32'd5);
        chk("addi wen", 32'(out_wen), 32'd1);

        // load-use: one bubble then add
        put(1'b1, LW); step();
        put(1'b1, ADD);
        #1 chk("lu in_ready stall", 32'(in_ready), 32'd0);
        step();
        chk("lu bubble", 32'(out_valid), 32'd0);
        chk("lu in_ready after", 32'(in_ready), 32'd1);
        step();
        chk("lu add valid", 32'(out_valid), 32'd1);
        chk("lu add rd", 32'(out_rd), 32'd7);
        chk("lu add insn", out_insn, ADD);

        // beq x1,x2,-8
        put(1'b1, BEQ);
        #1 chk("beq rs1pass", 32'(rs1pass), 32'd1);
        chk("beq rs2pass", 32'(rs2pass), 32'd1);
        step();
        chk("beq imm", out_imm, 32'hFFFF_FFF8);
        chk("beq wen", 32'(out_wen), 32'd0);

        // flush during load-use stall
        put(1'b1, LW); step();
        put(1'b1, ADD);
        #1 chk("fl stall", 32'(in_ready), 32'd0);
        flush = 1'b1;
        #1 chk("fl in_ready", 32'(in_ready), 32'd1);
        step();
        chk("fl out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        #1 chk("fl in_ready after", 32'(in_ready), 32'd1);
        step();
        chk("fl discarded", 32'(out_valid), 32'd0);

        // EX back-pressure for 3 cycles
        put(1'b1, ADDI); step();
        out_ready = 1'b0;
        put(1'b1, BEQ);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp in_ready", 32'(in_ready), 32'd0);
            step();
            chk("bp valid", 32'(out_valid), 32'd1);
            chk("bp insn", out_insn, ADDI);
            chk("bp imm", out_imm, 32'd7);
        end
        out_ready = 1'b1;
        step();
        chk("bp release", out_insn, BEQ);

        // reset mid-stall, then an all-ones word
        put(1'b1, LW); step();
        put(1'b1, ADD);
        #1 chk("rs stall", 32'(in_ready), 32'd0);
        #1 rst = 1'b1;
        #1 chk("rs valid", 32'(out_valid), 32'd0);
        chk("rs insn", out_insn, NOP);
        chk("rs rd", 32'(out_rd), 32'd0);
        chk("rs pc", out_pc, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        #1 chk("rs in_ready", 32'(in_ready), 32'd1);
        put(1'b1, 32'hFFFF_FFFF); step();
        chk("ill valid", 32'(out_valid), 32'd1);
        chk("ill wen", 32'(out_wen), 32'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
        chk("ill flag", 32'(out_illegal), 32'd1);
`else
        chk("ill flag", 32'(out_illegal), 32'd0);
`endif
        in_valid = 1'b0;
        step();

        // Randomized traffic; IF side holds a word until it is accepted.
        put(1'b1, gen());
        for (int c = 0; c < 3000; c++) begin
            #1 took = (in_valid && in_ready) || flush;
            step();
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            if (took || !in_valid) put(($urandom_range(0, 9) < 8), gen());
            regfile[$urandom_range(0, 31)] = $urandom;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
